// File: rtl/ant_launcher_pkg.sv
// ant_launcher_pkg: shared packet, FSM, outstanding-entry types and helpers for the ant launcher
package ant_launcher_pkg;
  localparam int X_NODES = 4;
  localparam int Y_NODES = 4;
  localparam int XW = $clog2(X_NODES);
  localparam int YW = $clog2(Y_NODES);
  localparam int MEM_DEPTH = 4;
  localparam int MW = 3;
  localparam int DW = 16;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  typedef struct packed {
    logic ant;
    logic backward;
    logic [XW-1:0] x_source;
    logic [YW-1:0] y_source;
    logic [XW-1:0] x_dest;
    logic [YW-1:0] y_dest;
    logic [MW-1:0] num_memory;
    logic [MEM_DEPTH-1:0][XW-1:0] x_memory;
    logic [MEM_DEPTH-1:0][YW-1:0] y_memory;
    logic [DW-1:0] data;
  } packet_t;
  typedef enum logic [1:0] {IDLE, PICK, SEND} ant_state_e;
  typedef struct packed {
    logic valid;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [15:0] age;
    logic [15:0] stamp;
  } ant_outst_t;
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction
endpackage

// File: rtl/ant_launcher_outstanding_table.sv
// ant_outstanding_table: outstanding-ant table with lowest-free allocate, lowest-valid match, aging and timeout
module ant_outstanding_table
  import ant_launcher_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic [XW-1:0] alloc_dx,
  input  logic [YW-1:0] alloc_dy,
  input  logic [15:0]   stamp,
  input  logic          match_req,
  input  logic [XW-1:0] match_x,
  input  logic [YW-1:0] match_y,
  output logic          full,
  output logic          match_hit,
  output logic [15:0]   match_stamp,
  output logic [3:0]    timeout_num
);
  ant_outst_t tbl [MAX_OUTST];
  logic [MAX_OUTST-1:0] hit_vec, free_vec, to_vec, match_oh, alloc_oh;
  always_comb begin
    match_stamp = '0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      hit_vec[i] = match_req && tbl[i].valid && tbl[i].dx == match_x && tbl[i].dy == match_y;
      free_vec[i] = !tbl[i].valid;
    end
    match_oh = hit_vec & (~hit_vec + MAX_OUTST'(1));
    alloc_oh = free_vec & (~free_vec + MAX_OUTST'(1));
    // a matched entry is never also counted as timed out
    for (int i = 0; i < MAX_OUTST; i++) begin
      to_vec[i] = tbl[i].valid && tbl[i].age == 16'(TIMEOUT - 1) && !match_oh[i];
      match_stamp = match_stamp | (match_oh[i] ? tbl[i].stamp : 16'd0);
    end
    full = ~|free_vec;
    match_hit = |match_oh;
    timeout_num = 4'($countones(to_vec));
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (rst) tbl[i] <= '0;
      else if (alloc && alloc_oh[i]) tbl[i] <= '{valid: 1'b1, dx: alloc_dx, dy: alloc_dy, age: 16'd0, stamp: stamp};
      else if (match_oh[i] || to_vec[i]) tbl[i].valid <= 1'b0;
      else if (tbl[i].valid) tbl[i].age <= tbl[i].age + 16'd1;
    end
  end
endmodule

// File: rtl/ant_launcher.sv
// ant_launcher: periodically injects forward ants on the local port and sinks matching backward ants
module ant_launcher
  import ant_launcher_pkg::*;
#(
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0,
  parameter int ANT_PERIOD = 1024,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT = 4096,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output packet_t     o_data,
  output logic        o_data_val,
  input  logic        i_en,
  input  packet_t     i_data,
  input  logic        i_data_val,
  output logic [15:0] o_launched_cnt,
  output logic [15:0] o_returned_cnt,
  output logic [15:0] o_timeout_cnt,
  output logic [15:0] o_skip_cnt,
  output logic [15:0] o_last_rtt
);
  ant_state_e state;
  logic [15:0] per_cnt, lfsr, lfsr_n, ts, match_stamp;
  logic [3:0] rej, timeout_num;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic tick, reject, alloc, sink, full, match_hit, unused_bits;
  packet_t pkt;
  always_comb begin
    tick = i_enable && per_cnt == 16'(ANT_PERIOD - 1);
    lfsr_n = lfsr_step(lfsr);
    dx = lfsr_n[XW-1:0];
    dy = lfsr_n[XW +: YW];
    reject = int'(dx) >= X_NODES || int'(dy) >= Y_NODES || (int'(dx) == X_LOC && int'(dy) == Y_LOC);
    alloc = state == SEND && i_en;
    sink = i_data_val && i_data.ant && i_data.backward &&
           int'(i_data.x_dest) == X_LOC && int'(i_data.y_dest) == Y_LOC;
    pkt = '0;
    pkt.ant = 1'b1;
    pkt.x_source = XW'(X_LOC);
    pkt.y_source = YW'(Y_LOC);
    pkt.x_dest = dx;
    pkt.y_dest = dy;
  end
  assign unused_bits = ^i_data;
  ant_outstanding_table #(.MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)) u_table (
    .clk(i_clk),
    .rst(i_reset),
    .alloc(alloc),
    .alloc_dx(o_data.x_dest),
    .alloc_dy(o_data.y_dest),
    .stamp(ts),
    .match_req(sink),
    .match_x(i_data.x_source),
    .match_y(i_data.y_source),
    .full(full),
    .match_hit(match_hit),
    .match_stamp(match_stamp),
    .timeout_num(timeout_num)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      per_cnt <= '0;
      lfsr <= LFSR_SEED;
      rej <= '0;
      ts <= '0;
      o_data <= '0;
      o_data_val <= 1'b0;
      o_launched_cnt <= '0;
      o_returned_cnt <= '0;
      o_timeout_cnt <= '0;
      o_skip_cnt <= '0;
      o_last_rtt <= '0;
    end else begin
      ts <= ts + 16'd1;
      if (i_enable) per_cnt <= tick ? 16'd0 : per_cnt + 16'd1;
      if (alloc) o_launched_cnt <= sat_add(o_launched_cnt, 4'd1);
      if (match_hit) begin
        o_returned_cnt <= sat_add(o_returned_cnt, 4'd1);
        o_last_rtt <= ts - match_stamp;
      end
      o_timeout_cnt <= sat_add(o_timeout_cnt, timeout_num);
      case (state)
        IDLE:
          if (tick) begin
            if (full) o_skip_cnt <= sat_add(o_skip_cnt, 4'd1);
            else begin
              state <= PICK;
              rej <= '0;
            end
          end
        PICK:
          if (!i_enable) state <= IDLE;
          else begin
            lfsr <= lfsr_n;
            if (!reject) begin
              o_data <= pkt;
              o_data_val <= 1'b1;
              state <= SEND;
            end else if (rej == 4'd15) state <= IDLE;
            else rej <= rej + 4'd1;
          end
        SEND:
          if (i_en) begin
            o_data_val <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
